// File: rtl/lc3_chk_pkg.sv
// Shared types and constants for the LC-3 bus/datapath runtime checker.
package lc3_chk_pkg;

  typedef enum logic [1:0] {
    RST    = 2'd0,
    CHK    = 2'd1,
    RUN    = 2'd2,
    FAILED = 2'd3
  } chk_state_t;

  typedef enum logic [1:0] {
    ERR_CONTEND = 2'd0,
    ERR_FLOAT   = 2'd1,
    ERR_RESET   = 2'd2,
    ERR_WDOG    = 2'd3
  } err_code_t;

  // Condition flags expected right after reset: Z set, N and P clear.
  localparam logic [2:0] NZP_RESET = 3'b010;

  // Lowest-numbered error code present in an error vector {wdog,reset,float,contend}.
  function automatic err_code_t lowest_code(input logic [3:0] e);
    if (e[0]) return ERR_CONTEND;
    if (e[1]) return ERR_FLOAT;
    if (e[2]) return ERR_RESET;
    return ERR_WDOG;
  endfunction

endpackage

// File: rtl/lc3_bus_checker_if.sv
// Observed LC-3 datapath signals: the CPU side drives them, the checker samples them.
interface lc3_bus_checker_if #(
  parameter int W       = 16,
  parameter int NUM_DRV = 4,
  parameter int NUM_LD  = 4
);
  logic [NUM_DRV-1:0] ena;
  logic [NUM_LD-1:0]  ld;
  logic               ldIR;
  logic [W-1:0]       PCOut;
  logic [W-1:0]       IR;
  logic [2:0]         nzp;
  logic               clr;

  modport master (output ena, ld, ldIR, PCOut, IR, nzp, clr);
  modport slave  (input  ena, ld, ldIR, PCOut, IR, nzp, clr);
endinterface

// File: rtl/lc3_popcnt.sv
// Combinational ones-count of an N-bit vector.
module lc3_popcnt #(
  parameter  int N  = 4,
  localparam int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_vec,
  output logic [OW-1:0] o_cnt
);

  // Sum the set bits of the input vector.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < N; i++) begin
      o_cnt = o_cnt + OW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/lc3_bus_checker.sv
// Runtime checker for the LC-3 datapath: bus contention, floating loads,
// post-reset register values and a fetch watchdog, with sticky flags,
// a saturating error counter and first-error capture.
module lc3_bus_checker
  import lc3_chk_pkg::*;
#(
  parameter int           W           = 16,
  parameter int           NUM_DRV     = 4,
  parameter int           NUM_LD      = 4,
  parameter logic [W-1:0] RESET_PC    = '0,
  parameter int           WDOG_MAX    = 64,
  parameter int           CNT_W       = 8,
  parameter int           CYC_W       = 16,
  parameter bit           STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  lc3_bus_checker_if.slave   bus,
  output logic               err_contend,
  output logic               err_float,
  output logic               err_reset,
  output logic               err_wdog,
  output logic               err_any,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [1:0]         first_code,
  output logic [CYC_W-1:0]   first_cyc,
  output logic               halted
);

  localparam int WD_W   = $clog2(WDOG_MAX + 1);
  localparam int DRV_CW = $clog2(NUM_DRV + 1);

  chk_state_t          r_state;
  chk_state_t          w_state_nxt;
  logic [3:0]          r_flags;
  logic [CNT_W-1:0]    r_err_cnt;
  err_code_t           r_first_code;
  logic [CYC_W-1:0]    r_first_cyc;
  logic [CYC_W-1:0]    r_cyc;
  logic [WD_W-1:0]     r_wdog;

  logic [DRV_CW-1:0]   w_drv_cnt;
  logic [2:0]          w_err_n;
  logic [3:0]          w_err;
  logic                w_bus_chk;
  logic [3:0]          w_flags_base;
  logic [CNT_W-1:0]    w_cnt_base;
  logic                w_first_open;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W+2:0] s;
    s = {3'b000, a} + {{CNT_W{1'b0}}, b};
    return (s > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  lc3_popcnt #(.N(NUM_DRV)) u_drv_cnt (.i_vec(bus.ena), .o_cnt(w_drv_cnt));
  lc3_popcnt #(.N(4))       u_err_cnt (.i_vec(w_err),   .o_cnt(w_err_n));

  // Bus-level checks run in CHK and RUN; register checks only in CHK; watchdog only in RUN.
  assign w_bus_chk = (r_state == CHK) || (r_state == RUN);
  assign w_err[0]  = w_bus_chk && (w_drv_cnt > DRV_CW'(1));
  assign w_err[1]  = w_bus_chk && (|bus.ld) && (bus.ena == '0);
  assign w_err[2]  = (r_state == CHK) &&
                     ((bus.PCOut != RESET_PC) || (bus.IR != '0) || (bus.nzp != NZP_RESET));
  // Fires only on the step into WDOG_MAX; the count then parks there.
  assign w_err[3]  = (r_state == RUN) && !bus.ldIR && (r_wdog == WD_W'(WDOG_MAX - 1));

  // clr wipes the old record first so an error in the same cycle still lands.
  assign w_flags_base = bus.clr ? 4'b0000 : r_flags;
  assign w_cnt_base   = bus.clr ? '0 : r_err_cnt;
  assign w_first_open = bus.clr || (r_flags == 4'b0000);

  // State register; a low rst forces RST from any state.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RST;
    else      r_state <= w_state_nxt;
  end

  // Next-state: one CHK cycle after reset release, then RUN; FAILED is absorbing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RST:     w_state_nxt = CHK;
      CHK:     w_state_nxt = (STOP_ON_ERR && w_err[2]) ? FAILED : RUN;
      RUN:     if (STOP_ON_ERR && (|w_err)) w_state_nxt = FAILED;
      FAILED:  w_state_nxt = FAILED;
      default: w_state_nxt = RST;
    endcase
  end

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) r_cyc <= '0;
    else      r_cyc <= r_cyc + CYC_W'(1);
  end

  // Watchdog: RUN cycles since the last ldIR, holding at WDOG_MAX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == RUN) begin
      if (bus.ldIR)                         r_wdog <= '0;
      else if (r_wdog != WD_W'(WDOG_MAX))   r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // Sticky flags, saturating count and first-error capture; frozen once FAILED.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flags      <= 4'b0000;
      r_err_cnt    <= '0;
      r_first_code <= ERR_CONTEND;
      r_first_cyc  <= '0;
    end else if (r_state != FAILED) begin
      r_flags   <= w_flags_base | w_err;
      r_err_cnt <= sat_add(w_cnt_base, w_err_n);
      if ((|w_err) && w_first_open) begin
        r_first_code <= lowest_code(w_err);
        r_first_cyc  <= r_cyc;
      end else if (bus.clr) begin
        r_first_code <= ERR_CONTEND;
        r_first_cyc  <= '0;
      end
    end
  end

  assign err_contend = r_flags[0];
  assign err_float   = r_flags[1];
  assign err_reset   = r_flags[2];
  assign err_wdog    = r_flags[3];
  assign err_any     = |r_flags;
  assign err_cnt     = r_err_cnt;
  assign first_code  = r_first_code;
  assign first_cyc   = r_first_cyc;
  assign halted      = (r_state == FAILED);

endmodule
